// File: rtl/systolic_mm_engine_if.sv
// rtl/systolic_mm_engine_if.sv - weight, activation and result stream bundle for systolic_mm_engine
//
// Purpose: groups the three valid/ready streams of the matrix-multiply engine.
// Signals:
//   w_valid/w_row/w_ready        weight row stream, lane j at [j*DW +: DW]
//   act_valid/act_vec/act_ready  activation row stream, lane i at [i*DW +: DW]
//   out_valid/out_vec/out_ready  result row stream, lane j at [j*AW +: AW]
// Modports: master drives weights/activations and accepts results,
//           slave is the engine side.
interface systolic_mm_engine_if #(
    parameter int N  = 3,
    parameter int DW = 32,
    parameter int AW = 64
);
    logic            w_valid;
    logic [N*DW-1:0] w_row;
    logic            w_ready;
    logic            act_valid;
    logic [N*DW-1:0] act_vec;
    logic            act_ready;
    logic            out_valid;
    logic [N*AW-1:0] out_vec;
    logic            out_ready;

    modport master (
        output w_valid, w_row, act_valid, act_vec, out_ready,
        input  w_ready, act_ready, out_valid, out_vec
    );

    modport slave (
        input  w_valid, w_row, act_valid, act_vec, out_ready,
        output w_ready, act_ready, out_valid, out_vec
    );
endinterface

// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - weight-stationary NxN systolic matrix-multiply engine
//
// Purpose: computes out = act * W per accepted activation row, W held in the array.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   load_start      request a weight reload (drains in-flight vectors first)
//   busy            any valid vector in flight, including a pending result
//   weights_loaded  a complete weight set is resident
//   bus             slave side of the weight / activation / result streams
module systolic_mm_engine #(
    parameter int N  = 3,
    parameter int DW = 32,
    parameter int AW = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    output logic                 busy,
    output logic                 weights_loaded,
    systolic_mm_engine_if.slave  bus
);
    localparam int RW = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, READY, DRAIN} state_t;

    state_t state_q, state_d;

    logic [RW-1:0] row_cnt;
    logic          row_last;
    logic          w_fire;
    logic          accept;
    logic          adv;

    logic signed [DW-1:0]   w_mem [N][N];
    logic signed [DW-1:0]   skew_out [N];
    logic signed [DW-1:0]   a_in [N][N];
    logic signed [DW-1:0]   a_reg [N][N-1];
    logic signed [AW-1:0]   p_in [N][N];
    logic signed [AW-1:0]   p_reg [N][N];
    logic signed [2*DW-1:0] prod [N][N];
    logic signed [AW-1:0]   dsk_out [N];

    // One valid bit per pipeline stage; the whole datapath shares the same stall.
    logic [2*N-1:0]  v_q;
    logic            out_valid_q;
    logic [N*AW-1:0] out_vec_q;

    // A pending result that is not being taken freezes the entire array.
    assign adv      = ~out_valid_q | bus.out_ready;
    assign accept   = bus.act_valid & bus.act_ready;
    assign w_fire   = bus.w_valid & bus.w_ready;
    assign row_last = (row_cnt == RW'(N - 1));
    assign busy     = (|v_q) | out_valid_q;

    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = out_vec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.w_ready    = 1'b0;
        bus.act_ready  = 1'b0;
        weights_loaded = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) state_d = LOAD;
            end
            LOAD: begin
                bus.w_ready = 1'b1;
                if (w_fire && row_last) state_d = READY;
            end
            READY: begin
                bus.act_ready  = adv;
                weights_loaded = 1'b1;
                // A vector accepted on this very edge is still in flight next cycle.
                if (load_start) state_d = (busy || accept) ? DRAIN : LOAD;
            end
            DRAIN: begin
                weights_loaded = 1'b1;
                if (!busy) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Weight storage: only written in LOAD, which is entered with the array empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    w_mem[r][c] <= '0;
                end
            end
        end else if (w_fire) begin
            for (int c = 0; c < N; c++) begin
                w_mem[row_cnt][c] <= bus.w_row[c*DW +: DW];
            end
            row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        end
    end

    // Input skew: lane i sits behind i+1 registers so it meets the partial sum
    // coming down from row i-1. Bubbles enter as zeros.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic signed [DW-1:0] sk [gi+1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= gi; k++) sk[k] <= '0;
            end else if (adv) begin
                sk[0] <= accept ? bus.act_vec[gi*DW +: DW] : '0;
                for (int k = 1; k <= gi; k++) sk[k] <= sk[k-1];
            end
        end

        assign skew_out[gi] = sk[gi];
    end

    // PE wiring: activations enter from the west, partial sums from the north.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gj == 0) begin : g_west
                assign a_in[gi][gj] = skew_out[gi];
            end else begin : g_east
                assign a_in[gi][gj] = a_reg[gi][gj-1];
            end

            if (gi == 0) begin : g_top
                assign p_in[gi][gj] = '0;
            end else begin : g_below
                assign p_in[gi][gj] = p_reg[gi-1][gj];
            end

            assign prod[gi][gj] = a_in[gi][gj] * w_mem[gi][gj];
        end
    end

    // PE registers; the product is sign-extended and the sum wraps at AW bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    p_reg[i][j] <= '0;
                end
                for (int j = 0; j < N - 1; j++) begin
                    a_reg[i][j] <= '0;
                end
            end
        end else if (adv) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    p_reg[i][j] <= p_in[i][j] + AW'(prod[i][j]);
                end
                for (int j = 0; j < N - 1; j++) begin
                    a_reg[i][j] <= a_in[i][j];
                end
            end
        end
    end

    // Output de-skew: column j finishes j cycles before the last column, so it
    // waits N-1-j cycles to line up with it.
    for (genvar gj = 0; gj < N; gj++) begin : g_dsk
        if (gj == N - 1) begin : g_direct
            assign dsk_out[gj] = p_reg[N-1][gj];
        end else begin : g_delay
            logic signed [AW-1:0] ds [N-1-gj];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < N - 1 - gj; k++) ds[k] <= '0;
                end else if (adv) begin
                    ds[0] <= p_reg[N-1][gj];
                    for (int k = 1; k < N - 1 - gj; k++) ds[k] <= ds[k-1];
                end
            end

            assign dsk_out[gj] = ds[N-2-gj];
        end
    end

    // Valid chain (2N stages) plus the output register gives the 2N-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
        end else if (adv) begin
            v_q         <= {v_q[2*N-2:0], accept};
            out_valid_q <= v_q[2*N-1];
            for (int j = 0; j < N; j++) begin
                out_vec_q[j*AW +: AW] <= dsk_out[j];
            end
        end
    end
endmodule

// File: doc/systolic_mm_engine.md
# systolic_mm_engine

Parametrised weight-stationary N×N systolic matrix-multiply engine with built-in input skew, output de-skew, valid/ready streaming and a weight-load state machine. It computes one output row per accepted activation row, out = act · W, with W held stationary in the array. It sits between the activation buffer and the result writeback path. It generalises the fixed 3×3 array by adding parametrised size and width, signed arithmetic, backpressure, and safe weight reload.

## Interface
- N, 3, array dimension (rows = columns = N), N ≥ 2
- DW, 32, signed activation/weight width
- AW, 64, signed accumulator/result width, AW ≥ 2·DW
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load_start  in  1  request weight reload
- w_valid  in  1  weight row valid
- w_row  in  N·DW  weight row r, lane j = W[r][j] at bits [j·DW +: DW]
- w_ready  out  1  weight row accepted when w_valid & w_ready
- act_valid  in  1  activation vector valid
- act_vec  in  N·DW  activation row, lane i at bits [i·DW +: DW]
- act_ready  out  1  activation accepted when act_valid & act_ready
- out_valid  out  1  result vector valid
- out_vec  out  N·AW  result, lane j = Σi act[i]·W[i][j]
- out_ready  in  1  downstream accepts result
- busy  out  1  any valid data in flight
- weights_loaded  out  1  full weight set resident

## Operation
- States: IDLE, LOAD, READY, DRAIN.
- IDLE (after reset): w_ready=0, act_ready=0. load_start=1 → LOAD.
- LOAD: w_ready=1; row counter r starts at 0, increments per accepted row; W[r] written; after row N-1 accepted → READY, weights_loaded=1. load_start ignored in LOAD. weights_loaded=0 throughout LOAD.
- READY: act_ready = adv, where adv = ~out_valid | out_ready. load_start=1: if busy=0 → LOAD directly; if busy=1 → DRAIN.
- DRAIN: act_ready=0; in-flight vectors complete using old weights; when busy=0 → LOAD.
- Datapath: activation lane i delayed i cycles (skew), moves east one PE per cycle; partial sums move south; column j output delayed N-1-j cycles (de-skew) so all lanes of a vector emerge together. A valid bit travels with each vector; bubbles are permitted.
- Global stall: every pipeline, skew and de-skew register advances only when adv=1. With out_valid=1 and out_ready=0, out_vec and out_valid hold and act_ready=0.
- Arithmetic: products DW×DW signed, sign-extended to AW; sums wrap modulo 2^AW (no saturation).
- busy = OR of all in-flight valid bits, including out_valid.
- Reset: all state cleared; W=0; FSM=IDLE; out_valid=0, out_vec=0, w_ready=0, act_ready=0, busy=0, weights_loaded=0. Reset mid-operation discards in-flight vectors; no out_valid on the cycle after reset.

## Timing
- Latency: a vector accepted at edge k produces out_valid=1 after edge k+2N (6 for N=3), given adv=1 throughout. Each stall cycle adds one.
- Throughput: one vector per cycle when out_ready=1; results leave in acceptance order.
- LOAD takes exactly N accepted beats; READY is reached the cycle after the last beat.
- load_start coincident with act_valid&act_ready in READY: the vector is accepted and counted in busy. The FSM enters DRAIN.

## Test plan
- Reset: hold rst 3 cycles. All outputs must be 0 and the FSM in IDLE. act_valid=1 must not be accepted.
- Basic 3×3: load W rows [1,2,3],[4,5,6],[7,8,9]; stream act [1,2,3],[4,5,6],[7,8,9] back-to-back. The outputs must be [30,36,42], [66,81,96], [102,126,150] on consecutive cycles. The first output appears 6 cycles after its acceptance.
- Backpressure: repeat the basic test with out_ready=0 for 4 cycles from the first out_valid. out_vec must hold, act_ready must be 0, and no result may be lost or reordered.
- Signed/width: W row0=[-5,3,2^31-1], other rows 0; act [-1,0,0]. Output must be [5,-3,-(2^31-1)], sign-correct in 64 bits.
- Reload under load: assert load_start while 2 vectors are in flight. Both must complete with the old weights. DRAIN→LOAD follows, and the next vector must use the new weights.
- Reset mid-stream: assert rst while 3 vectors are in flight. No out_valid may follow, and weights_loaded must be 0.
